// File: rtl/d_reg_pkg.sv
// Shared definitions for the d_reg_pipe register pipeline.
// Action encoding and fill counter width helper.
package d_reg_pkg;

    localparam logic [1:0] ACT_HOLD  = 2'd0;
    localparam logic [1:0] ACT_SHIFT = 2'd1;
    localparam logic [1:0] ACT_LOAD  = 2'd2;
    localparam logic [1:0] ACT_CLR   = 2'd3;

    // Bits needed to count 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        int w;
        w = 1;
        while ((1 << w) <= depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/d_reg_stage.sv
// One data+valid stage of the pipeline.
// Async reset, then clr > ld > shift > hold as selected by act.
module d_reg_stage
    import d_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [1:0]       act,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            q       <= RESET_VAL;
            q_valid <= 1'b0;
        end else begin
            case (act)
                ACT_CLR: begin
                    q       <= RESET_VAL;
                    q_valid <= 1'b0;
                end
                ACT_LOAD: begin
                    q       <= ld_val;
                    q_valid <= 1'b1;
                end
                ACT_SHIFT: begin
                    q       <= d;
                    q_valid <= d_valid;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/d_reg_pipe.sv
// DEPTH-stage WIDTH-bit register pipeline with valid tracking.
// Incremental fill counter; all outputs are registered.
module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    input  logic                          ld,
    input  logic [WIDTH*DEPTH-1:0]        ld_data,
    input  logic [WIDTH-1:0]              D,
    input  logic                          D_valid,
    output logic [WIDTH-1:0]              Q,
    output logic                          Q_valid,
    output logic [WIDTH*DEPTH-1:0]        taps,
    output logic [clog2_cnt(DEPTH)-1:0]   fill_count
);

    localparam int CW = clog2_cnt(DEPTH);

    logic [1:0]       act;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic             stage_v [DEPTH];

    always_comb begin
        act = ACT_HOLD;
        if (clr)     act = ACT_CLR;
        else if (ld) act = ACT_LOAD;
        else if (en) act = ACT_SHIFT;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        logic             v_in;
        if (i == 0) begin : g_head
            assign d_in = D;
            assign v_in = D_valid;
        end else begin : g_body
            assign d_in = stage_q[i-1];
            assign v_in = stage_v[i-1];
        end

        d_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CLK     (CLK),
            .reset   (reset),
            .act     (act),
            .d       (d_in),
            .d_valid (v_in),
            .ld_val  (ld_data[i*WIDTH +: WIDTH]),
            .q       (stage_q[i]),
            .q_valid (stage_v[i])
        );

        assign taps[i*WIDTH +: WIDTH] = stage_q[i];
    end

    assign Q       = stage_q[DEPTH-1];
    assign Q_valid = stage_v[DEPTH-1];

    // Tracks popcount(valid) without an adder tree.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fill_count <= '0;
        end else begin
            case (act)
                ACT_CLR:  fill_count <= '0;
                ACT_LOAD: fill_count <= CW'(DEPTH);
                ACT_SHIFT: begin
                    if (D_valid && !stage_v[DEPTH-1])
                        fill_count <= fill_count + CW'(1);
                    else if (!D_valid && stage_v[DEPTH-1])
                        fill_count <= fill_count - CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed and randomised checks for d_reg_pipe.
// WIDTH=8, DEPTH=4, RESET_VAL=0, 10 ns clock.
module tb_d_reg_pipe;

    logic        CLK;
    logic        reset;
    logic        en;
    logic        clr;
    logic        ld;
    logic [31:0] ld_data;
    logic [7:0]  D;
    logic        D_valid;
    logic [7:0]  Q;
    logic        Q_valid;
    logic [31:0] taps;
    logic [2:0]  fill_count;

    int n_tests;
    int n_fail;

    logic [7:0] m_data [4];
    logic       m_valid [4];

    d_reg_pipe #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .ld         (ld),
        .ld_data    (ld_data),
        .D          (D),
        .D_valid    (D_valid),
        .Q          (Q),
        .Q_valid    (Q_valid),
        .taps       (taps),
        .fill_count (fill_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic e, input logic [7:0] d,
                         input logic dv);
        en      = e;
        D       = d;
        D_valid = dv;
    endtask

    function automatic logic [31:0] m_taps();
        logic [31:0] t;
        for (int i = 0; i < 4; i++) t[i*8 +: 8] = m_data[i];
        return t;
    endfunction

    function automatic logic [31:0] m_pop();
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    task automatic model_edge();
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                m_data[i]  = 8'h00;
                m_valid[i] = 1'b0;
            end
        end else if (ld) begin
            for (int i = 0; i < 4; i++) begin
                m_data[i]  = ld_data[i*8 +: 8];
                m_valid[i] = 1'b1;
            end
        end else if (en) begin
            for (int i = 3; i > 0; i--) begin
                m_data[i]  = m_data[i-1];
                m_valid[i] = m_valid[i-1];
            end
            m_data[0]  = D;
            m_valid[0] = D_valid;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        en      = 1'b0;
        clr     = 1'b0;
        ld      = 1'b0;
        ld_data = '0;
        D       = '0;
        D_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #3 reset = 1'b0;

        // reset state and async reset with a full pipe
        step();
        check("rst_q", Q, 8'h00);
        check("rst_cnt", fill_count, 3'd0);
        ld = 1'b1;
        ld_data = 32'hDEADBEEF;
        step();
        ld = 1'b0;
        check("pre_rst_cnt", fill_count, 3'd4);
        #2 reset = 1'b1;
        #1;
        check("async_q", Q, 8'h00);
        check("async_qv", Q_valid, 1'b0);
        check("async_cnt", fill_count, 3'd0);
        check("async_taps", taps, 32'h0);
        en = 1'bx; ld = 1'bx; clr = 1'bx;
        D = 8'hxx; D_valid = 1'bx; ld_data = 'x;
        step();
        check("rst_x_taps", taps, 32'h0);
        check("rst_x_cnt", fill_count, 3'd0);
        en = 1'b0; ld = 1'b0; clr = 1'b0;
        D = 8'h00; D_valid = 1'b0; ld_data = '0;
        #2 reset = 1'b0;

        // shift four valid words
        drive(1, 8'hA1, 1); step(); check("sh_cnt1", fill_count, 3'd1);
        drive(1, 8'hA2, 1); step(); check("sh_cnt2", fill_count, 3'd2);
        drive(1, 8'hA3, 1); step(); check("sh_cnt3", fill_count, 3'd3);
        check("sh_qv3", Q_valid, 1'b0);
        drive(1, 8'hA4, 1); step(); check("sh_cnt4", fill_count, 3'd4);
        check("sh_q", Q, 8'hA1);
        check("sh_qv", Q_valid, 1'b1);
        check("sh_taps", taps, 32'hA1A2A3A4);

        // stall after two words
        drive(0, 8'h00, 0);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_cnt", fill_count, 3'd0);
        drive(1, 8'hA1, 1); step();
        drive(1, 8'hA2, 1); step();
        drive(0, 8'h55, 1); step();
        check("stall_taps1", taps, 32'h0000A1A2);
        step();
        check("stall_taps2", taps, 32'h0000A1A2);
        check("stall_cnt", fill_count, 3'd2);
        drive(1, 8'hA3, 1); step();
        drive(1, 8'hA4, 1); step();
        check("stall_q", Q, 8'hA1);
        check("stall_qv", Q_valid, 1'b1);

        // full pipe keeps count, then bubbles drain it
        drive(1, 8'hA5, 1); step();
        check("full_cnt", fill_count, 3'd4);
        check("full_q", Q, 8'hA2);
        drive(1, 8'hEE, 0); step();
        check("bub_cnt1", fill_count, 3'd3);
        check("bub_qv1", Q_valid, 1'b1);
        step(); check("bub_cnt2", fill_count, 3'd2);
        step(); check("bub_cnt3", fill_count, 3'd1);
        check("bub_qv3", Q_valid, 1'b1);
        check("bub_q3", Q, 8'hA5);
        step(); check("bub_cnt4", fill_count, 3'd0);
        check("bub_qv4", Q_valid, 1'b0);
        check("bub_taps", taps, 32'hEEEEEEEE);
        step(); check("empty_cnt", fill_count, 3'd0);

        // load, then load+clr+en together
        drive(0, 8'h00, 0);
        ld = 1'b1;
        ld_data = 32'h44332211;
        step();
        check("ld_q", Q, 8'h44);
        check("ld_taps", taps, 32'h44332211);
        check("ld_cnt", fill_count, 3'd4);
        check("ld_qv", Q_valid, 1'b1);
        clr = 1'b1;
        drive(1, 8'h99, 1);
        step();
        check("ldclr_taps", taps, 32'h0);
        check("ldclr_cnt", fill_count, 3'd0);
        check("ldclr_qv", Q_valid, 1'b0);
        ld = 1'b0;
        clr = 1'b0;
        ld_data = 32'h55667788;
        ld = 1'b1;
        step();
        ld = 1'b0;
        check("ld_en_taps", taps, 32'h55667788);

        // random traffic against the model
        for (int i = 0; i < 4; i++) begin
            m_data[i]  = ld_data[i*8 +: 8];
            m_valid[i] = 1'b1;
        end
        for (int c = 0; c < 2000; c++) begin
            clr     = ($urandom_range(15) == 0);
            ld      = ($urandom_range(15) == 0);
            en      = ($urandom_range(3) != 0);
            D       = 8'($urandom);
            D_valid = 1'($urandom);
            ld_data = $urandom;
            model_edge();
            step();
            check("rnd_taps", taps, m_taps());
            check("rnd_qv", Q_valid, m_valid[3]);
            check("rnd_cnt", fill_count, m_pop());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
